truth_table_sweeper: RTL and testbench



---
 rtl/truth_sweep_pkg.sv | 29 ++
 rtl/settle_counter.sv | 34 +++
 rtl/truth_table_sweeper.sv | 115 +++++++++++
 tb/tb_truth_table_sweeper.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// rtl/truth_sweep_pkg.sv - shared types and constants for the truth table sweeper
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } sweep_state_t;

  localparam int         N_VECTORS        = 8;
  localparam int         IDX_W            = 3;
  localparam int         CNT_W            = 8;
  localparam logic [7:0] DEFAULT_EXPECTED = 8'h31;

  // Terminal count for the settle counter: the sample happens on count
  // SETTLE_CYCLES-1. Out-of-range settings are clamped to 1..255 so the
  // comparison always fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] settle_limit(input int settle_cycles);
    int s;
    s = settle_cycles;
    if (s < 1) begin
      s = 1;
    end else if (s > 255) begin
      s = 255;
    end
    return CNT_W'(s - 1);
  endfunction

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - loadable hold counter producing the per-vector sample strobe
module settle_counter
  import truth_sweep_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Terminal count is only meaningful while counting, so it doubles as the
  // sample strobe without further qualification by the caller.
  assign tc = en & (cnt == limit);

  // Count up while enabled; wrap to zero on terminal count so the next
  // vector starts a fresh hold without an extra load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps 8 input vectors through a 3-input block and checks its truth table (option: TRUTH_SWEEP_STOP_ON_MISMATCH_EN)
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXPECTED      = DEFAULT_EXPECTED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_q,
  output logic [2:0] fail_idx
);

  localparam logic [CNT_W-1:0] LIMIT    = settle_limit(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS - 1);

  sweep_state_t     state;
  sweep_state_t     state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] vec_q;
  logic             mismatch;
  logic             accept;
  logic             counting;
  logic             sample;
  logic             first_miss;
  logic             finish;

  // start is honoured only when no sweep is in flight.
  assign accept   = start & ((state == IDLE) | (state == DONE));
  assign counting = (state == SETTLE);

  settle_counter #(
    .W (CNT_W)
  ) u_settle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val ('0),
    .en       (counting),
    .limit    (LIMIT),
    .tc       (sample)
  );

  // Only the lowest failing vector is recorded.
  assign first_miss = sample & (y != EXPECTED[idx]) & ~mismatch;

`ifdef TRUTH_SWEEP_STOP_ON_MISMATCH_EN
  assign finish = sample & ((idx == LAST_IDX) | first_miss);
`else
  assign finish = sample & (idx == LAST_IDX);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: sweep on start, leave SETTLE after the final sample.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = SETTLE;
      SETTLE:  if (finish) state_nxt = DONE;
      DONE:    if (start)  state_nxt = SETTLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Vector index, stimulus register and capture/compare results.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx      <= '0;
      vec_q    <= '0;
      table_q  <= '0;
      fail_idx <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      vec_q    <= '0;
      table_q  <= '0;
      fail_idx <= '0;
      mismatch <= 1'b0;
    end else if (sample) begin
      table_q[idx] <= y;
      if (first_miss) begin
        fail_idx <= idx;
        mismatch <= 1'b1;
      end
      if (finish) begin
        vec_q <= '0;
      end else begin
        idx   <= idx + 1'b1;
        vec_q <= idx + 1'b1;
      end
    end
  end

  assign {a, b, c} = vec_q;
  assign busy      = (state == SETTLE);
  assign done      = (state == DONE);
  assign pass      = done & ~mismatch;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;
  import truth_sweep_pkg::*;

  localparam int         S_A = 2;
  localparam int         S_B = 1;
  localparam logic [7:0] EXP = 8'h31;
`ifdef TRUTH_SWEEP_STOP_ON_MISMATCH_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] fidx;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic       a_a, b_a, c_a, y_a, busy_a, done_a, pass_a;
  logic       a_b, b_b, c_b, y_b, busy_b, done_b, pass_b;
  logic [7:0] tbl_a, tbl_b;
  logic [2:0] fidx_a, fidx_b;
  logic [7:0] mask_a, mask_b;
  logic       slow_b;
  logic       y_b_slow = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   left_a = 0, left_b = 0, acc_a = 0, acc_b = 0;
  logic dprev_a = 1'b0, dprev_b = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_new, e_a, e_b;

  always #5 clk = ~clk;

  // Function under characterization: y = ~b & (a | ~c).
  function automatic logic ref_fn(input logic [2:0] v);
    return ~v[1] & (v[2] | ~v[0]);
  endfunction

  // Block A: instantaneous output with injectable per-vector faults.
  assign y_a = ref_fn({a_a, b_a, c_a}) ^ mask_a[{a_a, b_a, c_a}];

  // Block B: optionally slow. A 15 ns output delay against a 10 ns clock is
  // only visible from the second edge after an input change.
  always @(posedge clk) y_b_slow <= ref_fn({a_b, b_b, c_b}) ^ mask_b[{a_b, b_b, c_b}];
  assign y_b = slow_b ? y_b_slow : (ref_fn({a_b, b_b, c_b}) ^ mask_b[{a_b, b_b, c_b}]);

  truth_table_sweeper #(.SETTLE_CYCLES(S_A), .EXPECTED(EXP)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .a(a_a), .b(b_a), .c(c_a), .y(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .table_q(tbl_a), .fail_idx(fidx_a));

  truth_table_sweeper #(.SETTLE_CYCLES(S_B), .EXPECTED(EXP)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .a(a_b), .b(b_b), .c(c_b), .y(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .table_q(tbl_b), .fail_idx(fidx_b));

  // Reference result of one sweep. With a slow block and one-cycle holds the
  // sampler still sees the previous vector's response (vector 000 before the first).
  function automatic exp_t predict(input logic [7:0] mask, input logic slow, input int s, input int now);
    exp_t e;
    int   src;
    logic got;
    logic found;
    int   len;
    e.tbl = 8'h00; e.pass = 1'b1; e.fidx = 3'd0; found = 1'b0; len = 8 * s;
    for (int i = 0; i < 8; i++) begin
      if (!(STOP && found)) begin
        src = (slow && s == 1 && i > 0) ? i - 1 : i;
        got = ref_fn(src[2:0]) ^ mask[src];
        e.tbl[i] = got;
        if (got != EXP[i] && !found) begin
          found  = 1'b1;
          e.fidx = i[2:0];
          e.pass = 1'b0;
          if (STOP) len = (i + 1) * s;
        end
      end
    end
    e.done_cyc = now + len;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Control model: a sweep is accepted only when none is outstanding; reset wins.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      left_a = 0; q_a.delete();
    end else if (left_a > 0) begin
      left_a--;
    end else if (start_a) begin
      e_new = predict(mask_a, 1'b0, S_A, cyc);
      q_a.push_back(e_new);
      acc_a = cyc; left_a = e_new.done_cyc - cyc;
    end
    if (reset) begin
      left_b = 0; q_b.delete();
    end else if (left_b > 0) begin
      left_b--;
    end else if (start_b) begin
      e_new = predict(mask_b, slow_b, S_B, cyc);
      q_b.push_back(e_new);
      acc_b = cyc; left_b = e_new.done_cyc - cyc;
    end
  end

  // Monitor: busy and stimulus every cycle; results on each rise of done.
  always @(negedge clk) begin
    check("busy_a", busy_a, left_a > 0);
    check("abc_a", {a_a, b_a, c_a}, (left_a > 0) ? (cyc - acc_a) / S_A : 0);
    if (done_a && !dprev_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_a_unexpected actual=1 required=0");
      end else begin
        e_a = q_a.pop_front();
        check("table_a", tbl_a, e_a.tbl);
        check("pass_a", pass_a, e_a.pass);
        check("fail_idx_a", fidx_a, e_a.fidx);
        check("done_cycle_a", cyc, e_a.done_cyc);
      end
    end
    dprev_a = done_a;

    check("busy_b", busy_b, left_b > 0);
    check("abc_b", {a_b, b_b, c_b}, (left_b > 0) ? (cyc - acc_b) / S_B : 0);
    if (done_b && !dprev_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_b_unexpected actual=1 required=0");
      end else begin
        e_b = q_b.pop_front();
        check("table_b", tbl_b, e_b.tbl);
        check("pass_b", pass_b, e_b.pass);
        check("fail_idx_b", fidx_b, e_b.fidx);
        check("done_cycle_b", cyc, e_b.done_cyc);
      end
    end
    dprev_b = done_b;
  end

  task automatic pulse(input int d);
    @(negedge clk);
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (((d == 0) ? left_a : left_b) > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout actual=%0d required=<400", n);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_a();
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_pass_a", pass_a, 0);
    check("rst_table_a", tbl_a, 0);
    check("rst_fail_idx_a", fidx_a, 0);
    check("rst_abc_a", {a_a, b_a, c_a}, 0);
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mask_a = 8'h00; mask_b = 8'h00; slow_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a();
    check("rst_done_b", done_b, 0);
    check("rst_table_b", tbl_b, 0);
    reset = 1'b0;

    // Clean sweep, then a single stuck-at-one on vector 3.
    pulse(0); wait_idle(0);
    check("done_held_a", done_a, 1);
    check("pass_held_a", pass_a, 1);
    mask_a = 8'h08;
    pulse(0); wait_idle(0);

    // start in DONE clears the results on the following cycle.
    mask_a = 8'h00;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("restart_done_a", done_a, 0);
    check("restart_pass_a", pass_a, 0);
    check("restart_table_a", tbl_a, 0);
    wait_idle(0);

    // A second start mid-sweep is ignored.
    pulse(0);
    repeat (5) @(negedge clk);
    pulse(0);
    wait_idle(0);

    // Reset five cycles into a sweep, then a clean sweep.
    pulse(0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_a();
    reset = 1'b0;
    pulse(0); wait_idle(0);

    // start held high: back-to-back sweeps with one DONE cycle between.
    start_a = 1'b1;
    repeat (3 * (8 * S_A + 1)) @(negedge clk);
    start_a = 1'b0;
    wait_idle(0);

    // Block B with one-cycle holds: fast block passes, slow block does not.
    slow_b = 1'b0; pulse(1); wait_idle(1);
    slow_b = 1'b1; pulse(1); wait_idle(1);

    // Randomized faults, delays and target instance.
    for (int k = 0; k < 16; k++) begin
      int d;
      logic [7:0] m;
      d = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0:       m = 8'h00;
        1:       m = 8'h01 << $urandom_range(0, 7);
        default: m = 8'($urandom);
      endcase
      if (d == 0) mask_a = m;
      else begin
        mask_b = m; slow_b = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse(d);
      wait_idle(d);
    end

    repeat (2) @(negedge clk);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
